// File: rtl/vram_write_engine.sv
// rtl/vram_write_engine.sv - blank-gated video RAM write engine with command FIFO and hardware screen fill
module vram_write_engine #(
    parameter int ADDR_W    = 10,
    parameter int COLOR_W   = 3,
    parameter int DEPTH     = 8,
    parameter int LAST_CELL = 1023
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      iWrite,
    input  logic [ADDR_W-1:0]         iAddress,
    input  logic [COLOR_W-1:0]        iColor,
    input  logic                      iFill,
    input  logic [COLOR_W-1:0]        iFillColor,
    input  logic                      iBlank,
    input  logic                      iClearOvf,
    output logic                      oVramWe,
    output logic [ADDR_W-1:0]         oVramAddr,
    output logic [COLOR_W-1:0]        oVramData,
    output logic [$clog2(DEPTH):0]    oCount,
    output logic                      oFull,
    output logic                      oBusy,
    output logic                      oOverflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + COLOR_W;

    typedef enum logic {IDLE, FILL} state_t;

    state_t               state, stateNext;
    logic [ENTRY_W-1:0]   fifoMem [DEPTH];
    logic [PTR_W-1:0]     rdPtr, wrPtr;
    logic [CNT_W-1:0]     count;
    logic [ADDR_W-1:0]    fillCnt;
    logic [COLOR_W-1:0]   fillColor;
    logic [ENTRY_W-1:0]   headEntry;

    logic                 full;
    logic                 startFill;
    logic                 fillStep;
    logic                 fillDone;
    logic                 doPop;
    logic                 doPush;
    logic                 dropWrite;
    logic                 weNext;
    logic [ADDR_W-1:0]    addrNext;
    logic [COLOR_W-1:0]   dataNext;

    assign full      = (count == CNT_W'(DEPTH));
    assign headEntry = fifoMem[rdPtr];
    assign oCount    = count;
    assign oFull     = full;
    assign oBusy     = (state == FILL) || (count != '0);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iFill) stateNext = FILL;
            FILL:    if (iBlank && (fillCnt == ADDR_W'(LAST_CELL))) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // A fill start flushes the queue, so a same-cycle write is always accepted into the emptied FIFO.
    always_comb begin
        startFill = (state == IDLE) && iFill;
        fillStep  = (state == FILL) && iBlank;
        fillDone  = fillStep && (fillCnt == ADDR_W'(LAST_CELL));
        doPop     = (state == IDLE) && !iFill && iBlank && (count != '0);
        doPush    = iWrite && (startFill || !full);
        dropWrite = iWrite && full && !startFill;
        weNext    = doPop || fillStep;
        addrNext  = oVramAddr;
        dataNext  = oVramData;
        if (fillStep) begin
            addrNext = fillCnt;
            dataNext = fillColor;
        end else if (doPop) begin
            addrNext = headEntry[ENTRY_W-1:COLOR_W];
            dataNext = headEntry[COLOR_W-1:0];
        end
    end

    always_ff @(posedge Clock) begin
        if (doPush) begin
            fifoMem[startFill ? PTR_W'(0) : wrPtr] <= {iAddress, iColor};
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            fillCnt   <= '0;
            fillColor <= '0;
            oVramWe   <= 1'b0;
            oVramAddr <= '0;
            oVramData <= '0;
            oOverflow <= 1'b0;
        end else begin
            oVramWe   <= weNext;
            oVramAddr <= addrNext;
            oVramData <= dataNext;

            if (dropWrite) begin
                oOverflow <= 1'b1;
            end else if (iClearOvf) begin
                oOverflow <= 1'b0;
            end

            if (startFill) begin
                fillColor <= iFillColor;
                fillCnt   <= '0;
                rdPtr     <= '0;
                wrPtr     <= doPush ? PTR_W'(1) : PTR_W'(0);
                count     <= doPush ? CNT_W'(1) : CNT_W'(0);
            end else begin
                if (doPop) begin
                    rdPtr <= rdPtr + PTR_W'(1);
                end
                if (doPush) begin
                    wrPtr <= wrPtr + PTR_W'(1);
                end
                case ({doPush, doPop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end

            // The sweep parks on the last cell instead of wrapping back to zero.
            if (fillStep && !fillDone) begin
                fillCnt <= fillCnt + ADDR_W'(1);
            end
        end
    end

endmodule
